// File: rtl/regfile_wr_arbiter_pkg.sv
// rf_pkg: constants and state encoding shared by the register-file write
// arbiter, its bus interface and its sub-modules.
//   REG_CNT     number of architectural registers
//   REG_ADDR_W  register index width
//   DEF_DATA_W  default register data width
//   LAST_REG    highest register index, last one cleared during INIT
//   state_t     arbiter FSM states (INIT clears the file, RUN arbitrates)
package rf_pkg;
    localparam int REG_CNT    = 16;
    localparam int REG_ADDR_W = 4;
    localparam int DEF_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] LAST_REG = REG_ADDR_W'(REG_CNT - 1);

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;
endpackage

// File: rtl/regfile_wr_arbiter_if.sv
// regfile_wr_arbiter_if: requester and register-file write-port signals of
// the arbiter.
//   req_valid/req_dest/req_data  per-requester write requests (packed slices)
//   req_ready                    per-requester accept, at most one bit set
//   rf_busy                      register-file write port unavailable
//   rf_we/rf_wdest/rf_wdata      register-file write port
//   rf_decOut                    one-hot write enable
//   init_done                    register clearing has completed
// Modports: master = requester/register-file side, slave = arbiter.
interface regfile_wr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = rf_pkg::DEF_DATA_W
);
    logic [NUM_REQ-1:0]                    req_valid;
    logic [NUM_REQ*rf_pkg::REG_ADDR_W-1:0] req_dest;
    logic [NUM_REQ*DATA_W-1:0]             req_data;
    logic [NUM_REQ-1:0]                    req_ready;
    logic                                  rf_busy;
    logic                                  rf_we;
    logic [rf_pkg::REG_ADDR_W-1:0]         rf_wdest;
    logic [rf_pkg::REG_CNT-1:0]            rf_decOut;
    logic [DATA_W-1:0]                     rf_wdata;
    logic                                  init_done;

    modport master (
        output req_valid, req_dest, req_data, rf_busy,
        input  req_ready, rf_we, rf_wdest, rf_decOut, rf_wdata, init_done
    );

    modport slave (
        input  req_valid, req_dest, req_data, rf_busy,
        output req_ready, rf_we, rf_wdest, rf_decOut, rf_wdata, init_done
    );
endinterface

// File: rtl/regfile_wr_arbiter_dec.sv
// decoder4to16: binary register index to one-hot select.
//   sel     4-bit index
//   onehot  bit sel set, all others clear
module decoder4to16 (
    input  logic [3:0]  sel,
    output logic [15:0] onehot
);
    always_comb begin
        onehot = 16'h0001 << sel;
    end
endmodule

// File: rtl/regfile_wr_arbiter_rr.sv
// rr_arbiter: combinational round-robin selector.
//   req         request vector
//   last_grant  index of the previous winner; search starts one above it
//   enable      when low no grant is issued
//   grant       one-hot grant (all zero if disabled or nothing requested)
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    input  logic          enable,
    output logic [N-1:0]  grant
);
    localparam int unsigned NU = N;

    int unsigned idx;
    logic        found;

    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        if (enable) begin
            for (int unsigned off = 1; off <= NU; off++) begin
                idx = (32'(last_grant) + off) % NU;
                if (!found && req[idx[IW-1:0]]) begin
                    grant[idx[IW-1:0]] = 1'b1;
                    found = 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: clears all 16 registers after reset, then arbitrates
// NUM_REQ write requesters round-robin onto the single register-file write
// port with one cycle of write latency.
//   clk    single clock, rising edge
//   reset  synchronous, active high; discards in-flight writes, restarts INIT
//   bus    regfile_wr_arbiter_if.slave (requests, accepts, write port)
// Optional build macro RF_ZERO_REG_EN: RUN writes to register 0 are accepted
// but suppressed on the write port (INIT still clears register 0).
module regfile_wr_arbiter
    import rf_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = DEF_DATA_W
) (
    input logic                 clk,
    input logic                 reset,
    regfile_wr_arbiter_if.slave bus
);
    localparam int          IW = $clog2(NUM_REQ);
    localparam int unsigned NR = NUM_REQ;

    state_t                  state, state_nxt;
    logic [REG_ADDR_W-1:0]   init_cnt;
    logic [IW-1:0]           last_grant, grant_idx;
    logic [NUM_REQ-1:0]      grant;
    logic                    arb_en, init_wr, accept, wr_en;
    logic [REG_ADDR_W-1:0]   sel_dest;
    logic [DATA_W-1:0]       sel_data;
    logic                    we_q;
    logic [REG_ADDR_W-1:0]   wdest_q;
    logic [DATA_W-1:0]       wdata_q;
    logic                    we_out;
    logic [REG_ADDR_W-1:0]   wdest_out;
    logic [DATA_W-1:0]       wdata_out;
    logic [REG_CNT-1:0]      dec_out;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) state <= INIT;
        else       state <= state_nxt;
    end

    // FSM next state: leave INIT once index 15 has actually been written
    always_comb begin
        state_nxt = state;
        if (state == INIT && init_wr && init_cnt == LAST_REG) state_nxt = RUN;
    end

    // FSM outputs: INIT drives the write port directly from the clear
    // counter, RUN presents the registered accept from the previous cycle.
    // Reset masks the write enable so an in-flight write never lands.
    always_comb begin
        init_wr = (state == INIT) && !bus.rf_busy;
        arb_en  = (state == RUN) && !bus.rf_busy;
        if (state == INIT) begin
            we_out    = init_wr;
            wdest_out = init_cnt;
            wdata_out = '0;
        end else begin
            we_out    = we_q;
            wdest_out = wdest_q;
            wdata_out = wdata_q;
        end
        we_out = we_out && !reset;
    end

    rr_arbiter #(.N(NUM_REQ), .IW(IW)) u_rr (
        .req        (bus.req_valid),
        .last_grant (last_grant),
        .enable     (arb_en),
        .grant      (grant)
    );

    // Grant is one-hot and only asserted on a valid requester, so any set
    // bit is an accept.
    always_comb begin
        grant_idx = '0;
        sel_dest  = '0;
        sel_data  = '0;
        for (int unsigned i = 0; i < NR; i++) begin
            if (grant[i]) begin
                grant_idx = IW'(i);
                sel_dest  = bus.req_dest[i*REG_ADDR_W +: REG_ADDR_W];
                sel_data  = bus.req_data[i*DATA_W +: DATA_W];
            end
        end
        accept = |grant;
`ifdef RF_ZERO_REG_EN
        wr_en = accept && (sel_dest != '0);
`else
        wr_en = accept;
`endif
    end

    // Datapath: clear counter, round-robin pointer, registered write port.
    // The INIT writes also load the hold registers so RUN starts out holding
    // the last cleared index.
    always_ff @(posedge clk) begin
        if (reset) begin
            init_cnt   <= '0;
            last_grant <= IW'(NUM_REQ - 1);
            we_q       <= 1'b0;
            wdest_q    <= '0;
            wdata_q    <= '0;
        end else begin
            we_q <= wr_en;
            if (init_wr) begin
                init_cnt <= init_cnt + 4'd1;
                wdest_q  <= init_cnt;
                wdata_q  <= '0;
            end
            if (accept) begin
                last_grant <= grant_idx;
                wdest_q    <= sel_dest;
                wdata_q    <= sel_data;
            end
        end
    end

    decoder4to16 u_dec (
        .sel    (wdest_out),
        .onehot (dec_out)
    );

    assign bus.req_ready = grant;
    assign bus.rf_we     = we_out;
    assign bus.rf_wdest  = wdest_out;
    assign bus.rf_wdata  = wdata_out;
    assign bus.rf_decOut = we_out ? dec_out : '0;
    assign bus.init_done = (state == RUN);
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Testbench for regfile_wr_arbiter: directed table and sequences for the
// clear phase, round-robin order, busy stalls, register-0 handling and reset
// during an in-flight write, plus randomized traffic against a reference
// model of the arbitration rules.
module tb_regfile_wr_arbiter;
    localparam int N  = 4;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    regfile_wr_arbiter_if #(.NUM_REQ(N), .DATA_W(DW)) bus ();

    regfile_wr_arbiter #(.NUM_REQ(N), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int tests = 0;
    int fails = 0;

    logic [3:0]   r_dest [N];
    logic [31:0]  r_data [N];
    logic [N-1:0] r_valid;

    // reference model state
    bit          m_init = 1'b1;
    int          m_cnt  = 0;
    int          m_last = N - 1;
    bit          m_pw   = 1'b0;
    int          m_hdest = 0;
    logic [31:0] m_hdata = '0;

    typedef struct {
        logic         busy;
        logic [N-1:0] valid;
        logic [N-1:0] ready;
        logic         we;
        logic [3:0]   wdest;
        logic [31:0]  wdata;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic rst, input logic busy, input logic [N-1:0] valid);
        reset = rst;
        bus.rf_busy = busy;
        bus.req_valid = valid;
        for (int i = 0; i < N; i++) begin
            bus.req_dest[i*4 +: 4]  = r_dest[i];
            bus.req_data[i*DW +: DW] = r_data[i];
        end
    endtask

    // first valid requester strictly after the previous winner, wrapping
    function automatic logic [N-1:0] m_ready();
        logic [N-1:0] r;
        r = '0;
        if (!m_init && !bus.rf_busy) begin
            for (int k = 1; k <= N; k++) begin
                int j;
                j = (m_last + k) % N;
                if (bus.req_valid[j] && r == '0) r[j] = 1'b1;
            end
        end
        return r;
    endfunction

    task automatic model_check();
        logic        exp_we;
        int          wd;
        logic [31:0] wdat;
        if (m_init) begin
            exp_we = !bus.rf_busy;
            wd     = m_cnt;
            wdat   = '0;
        end else begin
            exp_we = m_pw;
            wd     = m_hdest;
            wdat   = m_hdata;
        end
        if (reset) exp_we = 1'b0;
        check("m_we",     64'(bus.rf_we), 64'(exp_we));
        check("m_wdest",  64'(bus.rf_wdest), 64'(wd));
        check("m_wdata",  64'(bus.rf_wdata), 64'(wdat));
        check("m_decOut", 64'(bus.rf_decOut), exp_we ? (64'd1 << wd) : 64'd0);
        check("m_ready",  64'(bus.req_ready), 64'(m_ready()));
        check("m_done",   64'(bus.init_done), 64'(!m_init));
    endtask

    task automatic model_update(output logic [N-1:0] acc);
        acc = m_ready();
        if (reset) begin
            m_init = 1'b1; m_cnt = 0; m_last = N - 1;
            m_pw = 1'b0; m_hdest = 0; m_hdata = '0;
            acc = '0;
        end else if (m_init) begin
            m_pw = 1'b0;
            if (!bus.rf_busy) begin
                m_hdest = m_cnt;
                m_hdata = '0;
                if (m_cnt == 15) m_init = 1'b0;
                m_cnt = (m_cnt + 1) % 16;
            end
        end else begin
            m_pw = 1'b0;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    m_last  = i;
                    m_hdest = r_dest[i];
                    m_hdata = r_data[i];
`ifdef RF_ZERO_REG_EN
                    m_pw = (r_dest[i] != 4'd0);
`else
                    m_pw = 1'b1;
`endif
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        model_check();
    endtask

    task automatic advance(output logic [N-1:0] acc);
        @(posedge clk);
        model_update(acc);
        #1;
    endtask

    initial begin
        vec_t         tbl [11];
        logic [N-1:0] acc;
        logic         busy, rst;

        tbl[0]  = '{1'b0, 4'b1111, 4'b0001, 1'b0, 4'd15, 32'h0};
        tbl[1]  = '{1'b0, 4'b1111, 4'b0010, 1'b1, 4'd1,  32'h100};
        tbl[2]  = '{1'b0, 4'b1111, 4'b0100, 1'b1, 4'd2,  32'h101};
        tbl[3]  = '{1'b0, 4'b1111, 4'b1000, 1'b1, 4'd3,  32'h102};
        tbl[4]  = '{1'b0, 4'b1111, 4'b0001, 1'b1, 4'd4,  32'h103};
        tbl[5]  = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'd1,  32'h100};
        tbl[6]  = '{1'b0, 4'b0000, 4'b0000, 1'b0, 4'd1,  32'h100};
        tbl[7]  = '{1'b1, 4'b0101, 4'b0000, 1'b0, 4'd1,  32'h100};
        tbl[8]  = '{1'b0, 4'b0101, 4'b0100, 1'b0, 4'd1,  32'h100};
        tbl[9]  = '{1'b0, 4'b0101, 4'b0001, 1'b1, 4'd3,  32'h102};
        tbl[10] = '{1'b0, 4'b0000, 4'b0000, 1'b1, 4'd1,  32'h100};

        for (int i = 0; i < N; i++) begin
            r_dest[i] = 4'(i + 1);
            r_data[i] = 32'h100 + 32'(i);
        end
        r_valid = '0;

        // reset state, requests present to show they are ignored
        drive(1'b1, 1'b0, '1);
        advance(acc);
        sample();
        check("rst_we", 64'(bus.rf_we), 64'd0);
        check("rst_decOut", 64'(bus.rf_decOut), 64'd0);
        check("rst_wdest", 64'(bus.rf_wdest), 64'd0);
        check("rst_wdata", 64'(bus.rf_wdata), 64'd0);
        check("rst_ready", 64'(bus.req_ready), 64'd0);
        check("rst_done", 64'(bus.init_done), 64'd0);
        advance(acc);

        // clear phase without stalls: 16 writes, done on the 17th cycle
        drive(1'b0, 1'b0, '1);
        for (int k = 0; k < 16; k++) begin
            sample();
            check("init_we", 64'(bus.rf_we), 64'd1);
            check("init_wdest", 64'(bus.rf_wdest), 64'(k));
            check("init_decOut", 64'(bus.rf_decOut), 64'd1 << k);
            check("init_ready", 64'(bus.req_ready), 64'd0);
            check("init_done_lo", 64'(bus.init_done), 64'd0);
            advance(acc);
        end
        drive(1'b0, 1'b0, '0);
        sample();
        check("init_done_hi", 64'(bus.init_done), 64'd1);
        check("run_first_we", 64'(bus.rf_we), 64'd0);
        advance(acc);

        // round-robin table
        for (int v = 0; v < 11; v++) begin
            drive(1'b0, tbl[v].busy, tbl[v].valid);
            sample();
            check($sformatf("tbl%0d_ready", v), 64'(bus.req_ready), 64'(tbl[v].ready));
            check($sformatf("tbl%0d_we", v), 64'(bus.rf_we), 64'(tbl[v].we));
            check($sformatf("tbl%0d_wdest", v), 64'(bus.rf_wdest), 64'(tbl[v].wdest));
            check($sformatf("tbl%0d_wdata", v), 64'(bus.rf_wdata), 64'(tbl[v].wdata));
            check($sformatf("tbl%0d_decOut", v), 64'(bus.rf_decOut),
                  tbl[v].we ? (64'd1 << tbl[v].wdest) : 64'd0);
            advance(acc);
        end

        // requester 2 held through three busy cycles
        r_dest[2] = 4'd7;
        r_data[2] = 32'hDEADBEEF;
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 1'b1, 4'b0100);
            sample();
            check("busy_ready", 64'(bus.req_ready), 64'd0);
            advance(acc);
        end
        drive(1'b0, 1'b0, 4'b0100);
        sample();
        check("busy_accept", 64'(bus.req_ready), 64'b0100);
        advance(acc);
        drive(1'b0, 1'b0, '0);
        sample();
        check("busy_we", 64'(bus.rf_we), 64'd1);
        check("busy_decOut", 64'(bus.rf_decOut), 64'h0080);
        check("busy_wdata", 64'(bus.rf_wdata), 64'hDEADBEEF);
        advance(acc);

        // register 0 write from requester 1
        r_dest[1] = 4'd0;
        r_data[1] = 32'h5;
        drive(1'b0, 1'b0, 4'b0010);
        sample();
        check("zero_ready", 64'(bus.req_ready), 64'b0010);
        advance(acc);
        drive(1'b0, 1'b0, '0);
        sample();
`ifdef RF_ZERO_REG_EN
        check("zero_we", 64'(bus.rf_we), 64'd0);
        check("zero_decOut", 64'(bus.rf_decOut), 64'd0);
`else
        check("zero_we", 64'(bus.rf_we), 64'd1);
        check("zero_decOut", 64'(bus.rf_decOut), 64'h0001);
`endif
        advance(acc);

        // reset in the cycle after an accept drops that write
        r_dest[0] = 4'd9;
        r_data[0] = 32'hAA;
        drive(1'b0, 1'b0, 4'b0001);
        sample();
        check("rstw_accept", 64'(bus.req_ready), 64'b0001);
        advance(acc);
        drive(1'b1, 1'b0, '0);
        sample();
        check("rstw_we", 64'(bus.rf_we), 64'd0);
        check("rstw_decOut", 64'(bus.rf_decOut), 64'd0);
        advance(acc);
        drive(1'b0, 1'b0, '0);
        sample();
        check("rstw_init_we", 64'(bus.rf_we), 64'd1);
        check("rstw_init_wdest", 64'(bus.rf_wdest), 64'd0);
        check("rstw_init_wdata", 64'(bus.rf_wdata), 64'd0);
        check("rstw_init_done", 64'(bus.init_done), 64'd0);
        advance(acc);

        // clear phase with a three-cycle stall while index 5 is pending
        drive(1'b1, 1'b0, '0);
        advance(acc);
        for (int c = 1; c <= 20; c++) begin
            busy = (c >= 6 && c <= 8);
            drive(1'b0, busy, '0);
            sample();
            if (busy) begin
                check("stall_we", 64'(bus.rf_we), 64'd0);
                check("stall_wdest", 64'(bus.rf_wdest), 64'd5);
            end
            if (c == 19) check("stall_done_lo", 64'(bus.init_done), 64'd0);
            if (c == 20) check("stall_done_hi", 64'(bus.init_done), 64'd1);
            advance(acc);
        end

        // randomized traffic; requests stay stable until accepted
        r_valid = '0;
        for (int cyc = 0; cyc < 400; cyc++) begin
            for (int i = 0; i < N; i++) begin
                if (!r_valid[i] && $urandom_range(0, 2) == 0) begin
                    r_valid[i] = 1'b1;
                    r_dest[i]  = 4'($urandom_range(0, 15));
                    r_data[i]  = $urandom;
                end
            end
            busy = ($urandom_range(0, 3) == 0);
            rst  = ($urandom_range(0, 149) == 0);
            drive(rst, busy, r_valid);
            sample();
            advance(acc);
            r_valid = r_valid & ~acc;
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
